// File: rtl/mul_share_pkg.sv
// Shared types and sizing for the multiplier-sharing controller.
// Operand/product widths match the bit-serial signed multiplier it drives.
package mul_share_pkg;

  localparam int XW          = 12;
  localparam int ZW          = 2 * XW;
  localparam int TIMEOUT_DEF = 64;
  localparam int BCW         = 5;
  localparam int TCW         = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_WAIT,
    S_UNLOAD,
    S_RESP
  } state_e;

  typedef struct packed {
    logic          id;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
  } req_t;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Requester, response and multiplier-serial signals of the sharing controller.
// master = controller view, slave = clients plus multiplier view.
interface mul_share_ctrl_if;
  import mul_share_pkg::*;

  logic          req0_valid;
  logic [XW-1:0] req0_x;
  logic [XW-1:0] req0_y;
  logic          req0_ready;
  logic          req1_valid;
  logic [XW-1:0] req1_x;
  logic [XW-1:0] req1_y;
  logic          req1_ready;

  logic          rsp_valid;
  logic          rsp_id;
  logic [ZW-1:0] rsp_z;
  logic          rsp_err;
  logic          rsp_ready;

  logic          m_x_in;
  logic          m_y_in;
  logic          m_sx;
  logic          m_sy;
  logic          m_mul;
  logic          m_done;
  logic          m_fx;
  logic          m_fy;
  logic          m_sz;
  logic          m_z_out;

  modport master (
    input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    input  rsp_ready, m_done, m_fx, m_fy, m_z_out,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_err,
    output m_x_in, m_y_in, m_sx, m_sy, m_mul, m_sz
  );

  modport slave (
    output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    output rsp_ready, m_done, m_fx, m_fy, m_z_out,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_err,
    input  m_x_in, m_y_in, m_sx, m_sy, m_mul, m_sz
  );

endinterface

// File: rtl/mul_rr_arb.sv
// Two-way round-robin pick; the last-grant state lives in the caller.
module mul_rr_arb (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       gnt_o,
  output logic       id_o
);

  always_comb begin
    gnt_o = |valid_i;
    case (valid_i)
      2'b11:   id_o = ~last_grant_i;
      2'b10:   id_o = 1'b1;
      default: id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one bit-serial signed multiplier between two requesters: accept,
// shift operands in MSB first, start, wait for done, shift product out, respond.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mul_share_ctrl_if.master bus
);

  state_e         state_q;
  req_t           req_q;
  req_t           req_d;
  logic           last_q;
  logic [BCW-1:0] bcnt_q;
  logic [TCW-1:0] tcnt_q;
  logic           err_q;
  logic [ZW-1:0]  z_q;
  logic           sxy_q;
  logic           xin_q;
  logic           yin_q;
  logic           mul_q;
  logic           sz_q;
  logic           rsp_valid_q;

  logic           gnt;
  logic           gnt_id;
  logic           accept;

  mul_rr_arb u_arb (
    .valid_i      ({bus.req1_valid, bus.req0_valid}),
    .last_grant_i (last_q),
    .gnt_o        (gnt),
    .id_o         (gnt_id)
  );

  // Ready must be combinational: operands are only guaranteed on this cycle.
  assign accept         = (state_q == S_IDLE) && gnt && !rst;
  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept && gnt_id;

  always_comb begin
    req_d    = '0;
    req_d.id = gnt_id;
    req_d.x  = gnt_id ? bus.req1_x : bus.req0_x;
    req_d.y  = gnt_id ? bus.req1_y : bus.req0_y;
  end

  assign bus.m_sx      = sxy_q;
  assign bus.m_sy      = sxy_q;
  assign bus.m_x_in    = xin_q;
  assign bus.m_y_in    = yin_q;
  assign bus.m_mul     = mul_q;
  assign bus.m_sz      = sz_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = req_q.id;
  assign bus.rsp_z     = z_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      last_q      <= 1'b1;
      bcnt_q      <= '0;
      tcnt_q      <= '0;
      err_q       <= 1'b0;
      z_q         <= '0;
      sxy_q       <= 1'b0;
      xin_q       <= 1'b0;
      yin_q       <= 1'b0;
      mul_q       <= 1'b0;
      sz_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            // The MSB goes out next cycle; the rest is held pre-shifted.
            req_q.id <= req_d.id;
            req_q.x  <= {req_d.x[XW-2:0], 1'b0};
            req_q.y  <= {req_d.y[XW-2:0], 1'b0};
            xin_q    <= req_d.x[XW-1];
            yin_q    <= req_d.y[XW-1];
            last_q   <= req_d.id;
            err_q    <= 1'b0;
            sxy_q    <= 1'b1;
            bcnt_q   <= '0;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bcnt_q == BCW'(XW - 1)) begin
            sxy_q   <= 1'b0;
            xin_q   <= 1'b0;
            yin_q   <= 1'b0;
            mul_q   <= 1'b1;
            state_q <= S_MUL;
          end else begin
            xin_q   <= req_q.x[XW-1];
            yin_q   <= req_q.y[XW-1];
            req_q.x <= {req_q.x[XW-2:0], 1'b0};
            req_q.y <= {req_q.y[XW-2:0], 1'b0};
            bcnt_q  <= bcnt_q + 1'b1;
          end
        end
        S_MUL: begin
          // Full flags reflect the last shift only from this cycle on.
          if (!(bus.m_fx && bus.m_fy)) err_q <= 1'b1;
          mul_q   <= 1'b0;
          tcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.m_done) begin
            sz_q    <= 1'b1;
            bcnt_q  <= '0;
            state_q <= S_UNLOAD;
          end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
            err_q       <= 1'b1;
            z_q         <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_UNLOAD: begin
          z_q <= {z_q[ZW-2:0], bus.m_z_out};
          if (bcnt_q == BCW'(ZW - 1)) begin
            sz_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl with a behavioural bit-serial multiplier and a
// round-robin / product / latency reference model.
module tb_mul_share_ctrl;
  import mul_share_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  int   last_gnt = 1;

  int done_delay = 1;
  bit done_never = 1'b0;
  bit fault_fx   = 1'b0;
  bit stray_done = 1'b0;

  logic [XW-1:0] mx, my;
  logic [ZW-1:0] mz;
  int            nsx, nsy, dcnt;
  bit            busy;

  mul_share_ctrl_if bus();

  mul_share_ctrl #(.TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [ZW-1:0] smul(input logic signed [XW-1:0] a, input logic signed [XW-1:0] b);
    logic signed [ZW-1:0] aa, bb;
    aa = a;
    bb = b;
    return aa * bb;
  endfunction

  // behavioural multiplier
  assign bus.m_fx    = (nsx >= XW) && !fault_fx;
  assign bus.m_fy    = (nsy >= XW);
  assign bus.m_done  = (busy && !done_never && dcnt == done_delay) || stray_done;
  assign bus.m_z_out = mz[ZW-1];

  always @(posedge clk) begin
    if (rst) begin
      mx <= '0; my <= '0; mz <= '0; nsx <= 0; nsy <= 0; busy <= 1'b0; dcnt <= 0;
    end else begin
      if (bus.m_sx) begin mx <= {mx[XW-2:0], bus.m_x_in}; nsx <= nsx + 1; end
      if (bus.m_sy) begin my <= {my[XW-2:0], bus.m_y_in}; nsy <= nsy + 1; end
      if (bus.m_mul) begin
        mz <= smul(mx, my); nsx <= 0; nsy <= 0; busy <= 1'b1; dcnt <= 1;
      end else if (busy) begin
        if (!done_never && dcnt == done_delay) busy <= 1'b0;
        dcnt <= dcnt + 1;
      end
      if (bus.m_sz) mz <= {mz[ZW-2:0], 1'b0};
    end
  end

  // reference model
  function automatic logic [ZW-1:0] ref_prod(input logic [XW-1:0] x, input logic [XW-1:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[ZW-1:0];
  endfunction

  function automatic int rr_pick(input bit v0, input bit v1);
    if (v0 && v1) return 1 - last_gnt;
    return v1 ? 1 : 0;
  endfunction

  function automatic logic [34:0] outs();
    return {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_z,
            bus.m_x_in, bus.m_y_in, bus.m_sx, bus.m_sy, bus.m_mul, bus.m_sz};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int budget, output int id, output int t);
    id = -1;
    t  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        id = (bus.req0_ready && bus.req1_ready) ? 2 : int'(bus.req1_ready);
        t  = cyc;
        return;
      end
    end
  endtask

  task automatic wait_rsp(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin t = cyc; return; end
    end
  endtask

  task automatic pulse_reset();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    last_gnt = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_x = 12'h123; bus.req0_y = 12'h456;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs() !== '0) begin errs++; $display("FAIL reset_outs: got %h want 0", outs()); end
    bus.req0_valid = 1'b0;
    tick(); rst = 1'b0; last_gnt = 1;
    @(negedge clk);
    checks++;
    if (outs() !== '0) begin errs++; $display("FAIL idle_outs: got %h want 0", outs()); end
  endtask

  task automatic test_basic();
    int id, t0, tr;
    logic [XW-1:0] sx, sy, ex;
    bit ctl_ok;
    tick();
    done_delay = 2;
    bus.req0_x = 12'd3; bus.req0_y = 12'hFFB; bus.req0_valid = 1'b1;
    wait_accept(5, id, t0);
    checks++;
    if (id !== 0) begin errs++; $display("FAIL basic_grant: got %0d want 0", id); end
    last_gnt = 0;
    tick(); bus.req0_valid = 1'b0; bus.req0_x = 12'hABC; bus.req0_y = 12'h555;
    ctl_ok = 1'b1; sx = '0; sy = '0;
    for (int k = 0; k < XW; k++) begin
      @(negedge clk);
      if (!(bus.m_sx && bus.m_sy && !bus.m_mul)) ctl_ok = 1'b0;
      sx = {sx[XW-2:0], bus.m_x_in};
      sy = {sy[XW-2:0], bus.m_y_in};
      stray_done = (k == 4);
    end
    stray_done = 1'b0;
    ex = 12'b000000000011;
    checks++;
    if (!ctl_ok) begin errs++; $display("FAIL load_shift_en: sx/sy not high for 12 cycles"); end
    checks++;
    if (sx !== ex) begin errs++; $display("FAIL serial_x: got %b want %b", sx, ex); end
    checks++;
    if (sy !== 12'hFFB) begin errs++; $display("FAIL serial_y: got %h want FFB", sy); end
    @(negedge clk);
    checks++;
    if (bus.m_mul !== 1'b1 || bus.m_sx !== 1'b0) begin errs++; $display("FAIL mul_pulse: mul=%b sx=%b want 1 0", bus.m_mul, bus.m_sx); end
    @(negedge clk);
    checks++;
    if (bus.m_mul !== 1'b0) begin errs++; $display("FAIL mul_one_cycle: got %b want 0", bus.m_mul); end
    wait_rsp(200, tr);
    checks++;
    if (tr !== t0 + 38 + done_delay) begin errs++; $display("FAIL basic_latency: got %0d want %0d", tr - t0, 38 + done_delay); end
    checks++;
    if (bus.rsp_z !== 24'hFFFFF1 || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0)
      begin errs++; $display("FAIL basic_rsp: z=%h id=%b err=%b want FFFFF1 0 0", bus.rsp_z, bus.rsp_id, bus.rsp_err); end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL rsp_drop: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_tie();
    int id, t0, t1, tr;
    pulse_reset();
    done_delay = 3;
    bus.req0_x = 12'h7FF; bus.req0_y = 12'h7FF; bus.req1_x = 12'h800; bus.req1_y = 12'h800;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    wait_accept(5, id, t0);
    checks++;
    if (id !== 0) begin errs++; $display("FAIL tie_first: got %0d want 0", id); end
    last_gnt = 0;
    tick(); bus.req0_valid = 1'b0;
    wait_rsp(200, tr);
    checks++;
    if (bus.rsp_z !== 24'h3FF001 || bus.rsp_id !== 1'b0) begin errs++; $display("FAIL tie_rsp0: z=%h id=%b want 3FF001 0", bus.rsp_z, bus.rsp_id); end
    wait_accept(5, id, t1);
    checks++;
    if (id !== 1 || t1 !== tr + 1) begin errs++; $display("FAIL tie_second: id=%0d dt=%0d want 1 1", id, t1 - tr); end
    last_gnt = 1;
    tick(); bus.req1_valid = 1'b0;
    wait_rsp(200, tr);
    checks++;
    if (bus.rsp_z !== 24'h400000 || bus.rsp_id !== 1'b1) begin errs++; $display("FAIL tie_rsp1: z=%h id=%b want 400000 1", bus.rsp_z, bus.rsp_id); end
  endtask

  task automatic test_alternate();
    int id, t0, tr, eid;
    logic [ZW-1:0] ez;
    tick();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      done_delay = 1 + i;
      eid = rr_pick(1'b1, 1'b1);
      ez  = eid ? ref_prod(bus.req1_x, bus.req1_y) : ref_prod(bus.req0_x, bus.req0_y);
      wait_accept(5, id, t0);
      checks++;
      if (id !== eid) begin errs++; $display("FAIL alt_grant%0d: got %0d want %0d", i, id, eid); end
      last_gnt = eid;
      tick();
      if (eid == 1) begin bus.req1_x = 12'($urandom); bus.req1_y = 12'($urandom); end
      else          begin bus.req0_x = 12'($urandom); bus.req0_y = 12'($urandom); end
      wait_rsp(200, tr);
      checks++;
      if (bus.rsp_z !== ez || tr !== t0 + 38 + done_delay)
        begin errs++; $display("FAIL alt_rsp%0d: z=%h lat=%0d want %h %0d", i, bus.rsp_z, tr - t0, ez, 38 + done_delay); end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic test_timeout();
    int id, t0, tr;
    tick();
    done_never = 1'b1;
    bus.req1_x = 12'h012; bus.req1_y = 12'h034; bus.req1_valid = 1'b1;
    wait_accept(5, id, t0);
    checks++;
    if (id !== 1) begin errs++; $display("FAIL to_grant: got %0d want 1", id); end
    last_gnt = 1;
    tick(); bus.req1_valid = 1'b0;
    wait_rsp(200, tr);
    checks++;
    if (tr !== t0 + 14 + 64) begin errs++; $display("FAIL to_latency: got %0d want 78", tr - t0); end
    checks++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_z !== '0 || bus.rsp_id !== 1'b1)
      begin errs++; $display("FAIL to_rsp: err=%b z=%h id=%b want 1 0 1", bus.rsp_err, bus.rsp_z, bus.rsp_id); end
    done_never = 1'b0;
  endtask

  task automatic test_backpressure();
    int id, t0, tr, bad, tup, eid;
    logic [ZW-1:0] ez, ez2;
    tick();
    done_delay = 2;
    bus.rsp_ready = 1'b0;
    bus.req0_x = 12'($urandom); bus.req0_y = 12'($urandom); bus.req0_valid = 1'b1;
    ez = ref_prod(bus.req0_x, bus.req0_y);
    wait_accept(5, id, t0);
    last_gnt = 0;
    tick(); bus.req0_valid = 1'b0;
    wait_rsp(200, tr);
    bus.req0_x = 12'($urandom); bus.req0_y = 12'($urandom);
    bus.req1_x = 12'($urandom); bus.req1_y = 12'($urandom);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_z} !== {3'b100, ez} || bus.req0_ready || bus.req1_ready) begin
        if (bad == 0) $display("FAIL bp_hold: v=%b id=%b err=%b z=%h rdy=%b%b want 1 0 0 %h 00",
                               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_z, bus.req1_ready, bus.req0_ready, ez);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errs++;
    tick(); bus.rsp_ready = 1'b1; tup = cyc;
    eid = rr_pick(1'b1, 1'b1);
    ez2 = eid ? ref_prod(bus.req1_x, bus.req1_y) : ref_prod(bus.req0_x, bus.req0_y);
    wait_accept(5, id, t0);
    checks++;
    if (id !== eid || t0 !== tup + 1 || bus.rsp_valid !== 1'b0)
      begin errs++; $display("FAIL bp_release: id=%0d dt=%0d v=%b want %0d 1 0", id, t0 - tup, bus.rsp_valid, eid); end
    last_gnt = eid;
    tick(); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_rsp(200, tr);
    checks++;
    if (bus.rsp_z !== ez2 || bus.rsp_id !== eid[0]) begin errs++; $display("FAIL bp_next: z=%h id=%b want %h %0d", bus.rsp_z, bus.rsp_id, ez2, eid); end
  endtask

  task automatic test_fault_fx();
    int id, t0, tr;
    logic [ZW-1:0] ez;
    tick();
    fault_fx = 1'b1; done_delay = 1;
    bus.req0_x = 12'hF00; bus.req0_y = 12'h00F; bus.req0_valid = 1'b1;
    ez = ref_prod(bus.req0_x, bus.req0_y);
    wait_accept(5, id, t0);
    last_gnt = 0;
    tick(); bus.req0_valid = 1'b0;
    wait_rsp(200, tr);
    checks++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_z !== ez || tr !== t0 + 39)
      begin errs++; $display("FAIL load_fault: err=%b z=%h lat=%0d want 1 %h 39", bus.rsp_err, bus.rsp_z, tr - t0, ez); end
    fault_fx = 1'b0;
  endtask

  task automatic test_reset_mid();
    int id, t0, tr, seen;
    logic [ZW-1:0] ez;
    tick();
    done_delay = 2;
    bus.req0_x = 12'h321; bus.req0_y = 12'h9AB; bus.req0_valid = 1'b1;
    wait_accept(5, id, t0);
    tick(); bus.req0_valid = 1'b0;
    while (cyc < t0 + 25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== '0) begin errs++; $display("FAIL mid_reset_outs: got %h want 0", outs()); end
    rst = 1'b0; last_gnt = 1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (bus.rsp_valid) seen++; end
    checks++;
    if (seen != 0) begin errs++; $display("FAIL mid_reset_norsp: rsp_valid seen %0d cycles want 0", seen); end
    tick();
    bus.req1_x = 12'h0C8; bus.req1_y = 12'hF38; bus.req1_valid = 1'b1;
    ez = ref_prod(bus.req1_x, bus.req1_y);
    wait_accept(5, id, t0);
    last_gnt = 1;
    tick(); bus.req1_valid = 1'b0;
    wait_rsp(200, tr);
    checks++;
    if (id !== 1 || bus.rsp_z !== ez || bus.rsp_err !== 1'b0 || tr !== t0 + 40)
      begin errs++; $display("FAIL mid_reset_fresh: id=%0d z=%h err=%b lat=%0d want 1 %h 0 40", id, bus.rsp_z, bus.rsp_err, tr - t0, ez); end
  endtask

  task automatic test_random();
    int id, t0, tr, eid, pat;
    bit v0, v1;
    logic [ZW-1:0] ez;
    for (int i = 0; i < 10; i++) begin
      tick();
      pat = $urandom_range(1, 3);
      v0 = pat[0]; v1 = pat[1];
      done_delay = $urandom_range(1, 6);
      bus.req0_x = 12'($urandom); bus.req0_y = 12'($urandom);
      bus.req1_x = 12'($urandom); bus.req1_y = 12'($urandom);
      eid = rr_pick(v0, v1);
      ez  = eid ? ref_prod(bus.req1_x, bus.req1_y) : ref_prod(bus.req0_x, bus.req0_y);
      bus.req0_valid = v0; bus.req1_valid = v1;
      wait_accept(5, id, t0);
      checks++;
      if (id !== eid) begin errs++; $display("FAIL rnd_grant%0d: got %0d want %0d", i, id, eid); end
      last_gnt = eid;
      tick(); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      wait_rsp(200, tr);
      checks++;
      if (bus.rsp_z !== ez || bus.rsp_id !== eid[0] || bus.rsp_err !== 1'b0 || tr !== t0 + 38 + done_delay)
        begin errs++; $display("FAIL rnd_rsp%0d: z=%h id=%b err=%b lat=%0d want %h %0d 0 %0d",
                               i, bus.rsp_z, bus.rsp_id, bus.rsp_err, tr - t0, ez, eid, 38 + done_delay); end
    end
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
    bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
    bus.rsp_ready  = 1'b1;
    test_reset();
    test_basic();
    test_tie();
    test_alternate();
    test_timeout();
    test_backpressure();
    test_fault_fx();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #300000;
    errs++;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end

endmodule
